// File: rtl/sha3_block_padder.sv
// Packs 32-bit message words into one SHA-3 rate block and applies the
// 0x06 domain byte plus the final 0x80 pad bit; holds the block until f_ack.
module sha3_block_padder #(
   parameter int RATE_WORDS = 18
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [31:0]                in,
   input  logic                       in_ready,
   input  logic                       is_last,
   input  logic [1:0]                 byte_num,
   output logic                       buffer_full,
   output logic [32*RATE_WORDS-1:0]   out,
   output logic                       out_ready,
   input  logic                       f_ack
);

   localparam int CW = $clog2(RATE_WORDS + 1);
   localparam logic [CW-1:0] LAST_SLOT = CW'(RATE_WORDS - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(RATE_WORDS);

   logic [32*RATE_WORDS-1:0] blk;
   logic [CW-1:0]            cnt;
   logic                     pad;
   logic                     done;
   logic                     accept;
   logic                     last_slot;
   logic [31:0]              last_word;
   logic [31:0]              acc_word;
   logic [31:0]              pad_word;

   assign buffer_full = (cnt == FULL_CNT);
   assign out_ready   = buffer_full;
   assign out         = blk;
   assign last_slot   = (cnt == LAST_SLOT);
   assign accept      = in_ready & ~buffer_full & ~pad & ~done;

   always_comb begin
      last_word = 32'h0600_0000;
      case (byte_num)
         2'd0: last_word = 32'h0600_0000;
         2'd1: last_word = {in[31:24], 24'h06_0000};
         2'd2: last_word = {in[31:16], 16'h0600};
         2'd3: last_word = {in[31:8],  8'h06};
         default: last_word = 32'h0600_0000;
      endcase
      acc_word = is_last ? last_word : in;
      // Ending in the final slot merges the pad bit into the same word (0x06|0x80).
      if (is_last && last_slot)
         acc_word = acc_word | 32'h0000_0080;
      pad_word = last_slot ? 32'h0000_0080 : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blk  <= '0;
         cnt  <= '0;
         pad  <= 1'b0;
         done <= 1'b0;
      end else if (f_ack && buffer_full) begin
         blk <= '0;
         cnt <= '0;
      end else if (accept) begin
         blk <= {blk[32*RATE_WORDS-33:0], acc_word};
         cnt <= cnt + CW'(1);
         if (is_last) begin
            if (last_slot)
               done <= 1'b1;
            else
               pad <= 1'b1;
         end
      end else if (pad && !buffer_full) begin
         blk <= {blk[32*RATE_WORDS-33:0], pad_word};
         cnt <= cnt + CW'(1);
         if (last_slot) begin
            pad  <= 1'b0;
            done <= 1'b1;
         end
      end
   end

endmodule
